sprite_cache_arbiter: RTL and testbench

- Sequences and shares the single stb/ack/wr port of the sprite cache between two requesters.
- Requester 1 is the scanline lookup engine. It issues hcursor lookups under a display deadline.
- Requester 2 is the CPU sprite-table writer.
- The block adds a miss timeout, because the cache never acks a miss. It also adds a release cycle so the cache's stale ack clears, and an anti-starvation guard for CPU writes.

---
 rtl/sprite_cache_arbiter_if.sv | 41 ++++
 rtl/sprite_cache_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sprite_cache_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_cache_arbiter_if.sv
// Purpose : bundles the lookup, CPU-write and cache-side signals of sprite_cache_arbiter.
// Latency : none, wires only.
// Backpressure: none, wires only; flow control lives in the arbiter's handshakes.
//
// Modports:
//   master - requesters and cache model side: drives lk_req/lk_hcursor,
//            cpu_stb/cpu_idx/cpu_data and sc_ack/sc_found_sprite.
//   slave  - arbiter side: drives lk_done/lk_hit/lk_sprite, cpu_ack and the
//            sc_* cache command outputs.
interface sprite_cache_arbiter_if;
   logic        lk_req;
   logic [9:0]  lk_hcursor;
   logic        lk_done;
   logic        lk_hit;
   logic [63:0] lk_sprite;

   logic        cpu_stb;
   logic [4:0]  cpu_idx;
   logic [63:0] cpu_data;
   logic        cpu_ack;

   logic        sc_stb;
   logic        sc_wr;
   logic [9:0]  sc_hcursor;
   logic [63:0] sc_wr_sprite;
   logic [4:0]  sc_wr_idx;
   logic        sc_ack;
   logic [63:0] sc_found_sprite;

   modport master (
      output lk_req, lk_hcursor, cpu_stb, cpu_idx, cpu_data, sc_ack, sc_found_sprite,
      input  lk_done, lk_hit, lk_sprite, cpu_ack,
             sc_stb, sc_wr, sc_hcursor, sc_wr_sprite, sc_wr_idx
   );

   modport slave (
      input  lk_req, lk_hcursor, cpu_stb, cpu_idx, cpu_data, sc_ack, sc_found_sprite,
      output lk_done, lk_hit, lk_sprite, cpu_ack,
             sc_stb, sc_wr, sc_hcursor, sc_wr_sprite, sc_wr_idx
   );
endinterface

// File: rtl/sprite_cache_arbiter.sv
// Purpose : shares the single stb/ack/wr sprite-cache port between the scanline lookup engine and the CPU writer.
// Latency : hit -> lk_done 3 cycles after lk_req is sampled; miss -> LOOKUP_TIMEOUT+1; write -> cpu_ack 2 cycles after grant.
// Backpressure: requesters hold lk_req/cpu_stb until lk_done/cpu_ack; a pending write is forced ahead after STARVE_LIMIT lookup grants.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; clears state, counters and every output
//   bus   - sprite_cache_arbiter_if.slave: lk_* lookup handshake, cpu_* write
//           handshake, sc_* cache command/response
//
// Optional build macro SCARB_WRBUF_EN: adds a one-entry posted write buffer so
// cpu_ack is returned one cycle after cpu_stb instead of after the cache write.
module sprite_cache_arbiter #(
   parameter int LOOKUP_TIMEOUT = 3,   // 2..15
   parameter int STARVE_LIMIT   = 8    // 1..15
) (
   input  logic                  clk,
   input  logic                  reset,
   sprite_cache_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, RELEASE} state_t;

   localparam logic [3:0] TMO  = 4'(LOOKUP_TIMEOUT);
   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

   state_t      state;
   logic [3:0]  tcnt;
   logic [3:0]  starve_cnt;

   logic        lk_done_r, lk_hit_r, cpu_ack_r, sc_stb_r, sc_wr_r;
   logic [63:0] lk_sprite_r, sc_wr_sprite_r;
   logic [9:0]  sc_hcursor_r;
   logic [4:0]  sc_wr_idx_r;

   // What arbitration treats as "a CPU write is waiting" and where its payload comes from.
   logic        wr_pending;
   logic [4:0]  wr_idx_src;
   logic [63:0] wr_data_src;
   logic        lk_grant, wr_grant;

`ifdef SCARB_WRBUF_EN
   logic        buf_full;
   logic [4:0]  buf_idx;
   logic [63:0] buf_data;
   logic        lk_finishing;

   assign wr_pending  = buf_full;
   assign wr_idx_src  = buf_idx;
   assign wr_data_src = buf_data;
   // A lookup completing on this edge pulses lk_done next cycle; capture is held
   // off one cycle so cpu_ack never lands on top of lk_done.
   assign lk_finishing = (state == LOOKUP) && (bus.sc_ack || (tcnt == TMO));
`else
   assign wr_pending  = bus.cpu_stb;
   assign wr_idx_src  = bus.cpu_idx;
   assign wr_data_src = bus.cpu_data;
`endif

   // Lookup has priority unless the waiting write has been passed over STARVE_LIMIT times.
   assign lk_grant = (state == IDLE) && bus.lk_req && !(wr_pending && (starve_cnt == SLIM));
   assign wr_grant = (state == IDLE) && wr_pending && !lk_grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         tcnt           <= '0;
         starve_cnt     <= '0;
         lk_done_r      <= 1'b0;
         lk_hit_r       <= 1'b0;
         cpu_ack_r      <= 1'b0;
         sc_stb_r       <= 1'b0;
         sc_wr_r        <= 1'b0;
         lk_sprite_r    <= '0;
         sc_wr_sprite_r <= '0;
         sc_hcursor_r   <= '0;
         sc_wr_idx_r    <= '0;
`ifdef SCARB_WRBUF_EN
         buf_full       <= 1'b0;
         buf_idx        <= '0;
         buf_data       <= '0;
`endif
      end else begin
         lk_done_r <= 1'b0;
         lk_hit_r  <= 1'b0;
         cpu_ack_r <= 1'b0;

         case (state)
            IDLE: begin
               sc_stb_r <= 1'b0;
               sc_wr_r  <= 1'b0;
               if (lk_grant) begin
                  state        <= LOOKUP;
                  sc_stb_r     <= 1'b1;
                  sc_hcursor_r <= bus.lk_hcursor;
                  tcnt         <= 4'd1;
                  if (wr_pending && (starve_cnt != SLIM))
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (wr_grant) begin
                  state          <= WRITE;
                  sc_stb_r       <= 1'b1;
                  sc_wr_r        <= 1'b1;
                  sc_wr_idx_r    <= wr_idx_src;
                  sc_wr_sprite_r <= wr_data_src;
                  starve_cnt     <= '0;
               end
            end

            LOOKUP: begin
               // An ack on the final timeout cycle still counts as a hit.
               if (bus.sc_ack) begin
                  lk_sprite_r <= bus.sc_found_sprite;
                  lk_hit_r    <= 1'b1;
                  lk_done_r   <= 1'b1;
                  sc_stb_r    <= 1'b0;
                  state       <= RELEASE;
               end else if (tcnt == TMO) begin
                  lk_done_r <= 1'b1;
                  sc_stb_r  <= 1'b0;
                  state     <= RELEASE;
               end else begin
                  tcnt <= tcnt + 4'd1;
               end
            end

            WRITE: begin
               sc_stb_r <= 1'b0;
               sc_wr_r  <= 1'b0;
`ifndef SCARB_WRBUF_EN
               cpu_ack_r <= 1'b1;
`endif
               state <= RELEASE;
            end

            // One idle cycle with stb low so the cache's registered ack falls
            // before the next grant; any ack seen here is stale.
            RELEASE: state <= IDLE;

            default: state <= IDLE;
         endcase

`ifdef SCARB_WRBUF_EN
         if (wr_grant) begin
            buf_full <= 1'b0;
         end else if (bus.cpu_stb && !buf_full && !lk_finishing) begin
            buf_full  <= 1'b1;
            buf_idx   <= bus.cpu_idx;
            buf_data  <= bus.cpu_data;
            cpu_ack_r <= 1'b1;
         end
`endif
      end
   end

   assign bus.lk_done      = lk_done_r;
   assign bus.lk_hit       = lk_hit_r;
   assign bus.lk_sprite    = lk_sprite_r;
   assign bus.cpu_ack      = cpu_ack_r;
   assign bus.sc_stb       = sc_stb_r;
   assign bus.sc_wr        = sc_wr_r;
   assign bus.sc_hcursor   = sc_hcursor_r;
   assign bus.sc_wr_sprite = sc_wr_sprite_r;
   assign bus.sc_wr_idx    = sc_wr_idx_r;
endmodule

// File: tb/tb_sprite_cache_arbiter.sv
// Purpose : directed self-checking bench for sprite_cache_arbiter with a registered-ack cache model.
// Latency : inputs driven on the falling edge; outputs sampled on falling edges counted from the sampling edge.
// Backpressure: requesters hold their request until done/ack, as the arbiter expects.
module tb_sprite_cache_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        hit_en;
   logic [63:0] found;
   logic        cache_ack;
   int          wr_cnt;
   int          cmp_cnt = 0;
   int          fail_cnt = 0;

   sprite_cache_arbiter_if bif();

   sprite_cache_arbiter #(.LOOKUP_TIMEOUT(3), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   // Cache model: acks a lookup one cycle after seeing stb (never for misses), counts write cycles.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cache_ack <= 1'b0;
         wr_cnt    <= 0;
      end else begin
         cache_ack <= bif.sc_stb && !bif.sc_wr && hit_en;
         if (bif.sc_stb && bif.sc_wr) wr_cnt <= wr_cnt + 1;
      end
   end
   assign bif.sc_ack          = cache_ack;
   assign bif.sc_found_sprite = found;

   task automatic test_reset();
      reset = 1'b0;
      hit_en = 1'b1;
      found = 64'h0;
      bif.lk_req = 1'b0; bif.lk_hcursor = '0;
      bif.cpu_stb = 1'b0; bif.cpu_idx = '0; bif.cpu_data = '0;
      repeat (2) @(negedge clk);
      cmp_cnt++;
      if ({bif.lk_done, bif.lk_hit, bif.cpu_ack, bif.sc_stb, bif.sc_wr} !== 5'b0) begin
         fail_cnt++; $display("FAIL reset_flags: got %b want 00000",
            {bif.lk_done, bif.lk_hit, bif.cpu_ack, bif.sc_stb, bif.sc_wr});
      end
      cmp_cnt++;
      if (bif.lk_sprite !== 64'h0) begin
         fail_cnt++; $display("FAIL reset_lk_sprite: got %h want 0", bif.lk_sprite);
      end
      cmp_cnt++;
      if ({bif.sc_hcursor, bif.sc_wr_idx, bif.sc_wr_sprite} !== 79'h0) begin
         fail_cnt++; $display("FAIL reset_sc_bus: got %h/%h/%h want 0",
            bif.sc_hcursor, bif.sc_wr_idx, bif.sc_wr_sprite);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      cmp_cnt++;
      if ({bif.sc_stb, bif.lk_done} !== 2'b00) begin
         fail_cnt++; $display("FAIL idle_after_reset: got %b want 00", {bif.sc_stb, bif.lk_done});
      end
   endtask

   task automatic test_lookup_hit();
      hit_en = 1'b1; found = 64'hA5;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd100;
      @(negedge clk); // cycle 1
      cmp_cnt++;
      if ({bif.sc_stb, bif.sc_wr, bif.lk_done} !== 3'b100) begin
         fail_cnt++; $display("FAIL hit_c1_stb: got stb/wr/done=%b want 100",
            {bif.sc_stb, bif.sc_wr, bif.lk_done});
      end
      cmp_cnt++;
      if (bif.sc_hcursor !== 10'd100) begin
         fail_cnt++; $display("FAIL hit_hcursor: got %0d want 100", bif.sc_hcursor);
      end
      @(negedge clk); // cycle 2
      cmp_cnt++;
      if (bif.lk_done !== 1'b0) begin
         fail_cnt++; $display("FAIL hit_c2_done: got %b want 0", bif.lk_done);
      end
      @(negedge clk); // cycle 3
      cmp_cnt++;
      if ({bif.lk_done, bif.lk_hit} !== 2'b11) begin
         fail_cnt++; $display("FAIL hit_c3_done_hit: got %b want 11", {bif.lk_done, bif.lk_hit});
      end
      cmp_cnt++;
      if (bif.lk_sprite !== 64'hA5) begin
         fail_cnt++; $display("FAIL hit_sprite: got %h want a5", bif.lk_sprite);
      end
      bif.lk_req = 1'b0;
      @(negedge clk); // cycle 4
      cmp_cnt++;
      if ({bif.sc_stb, bif.lk_done} !== 2'b00) begin
         fail_cnt++; $display("FAIL hit_c4_release: got stb/done=%b want 00", {bif.sc_stb, bif.lk_done});
      end
   endtask

   task automatic test_lookup_miss();
      hit_en = 1'b0; found = 64'hDEAD;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd200;
      repeat (3) @(negedge clk); // cycle 3
      cmp_cnt++;
      if ({bif.sc_stb, bif.lk_done} !== 2'b10) begin
         fail_cnt++; $display("FAIL miss_c3: got stb/done=%b want 10", {bif.sc_stb, bif.lk_done});
      end
      @(negedge clk); // cycle 4
      cmp_cnt++;
      if ({bif.lk_done, bif.lk_hit, bif.sc_stb} !== 3'b100) begin
         fail_cnt++; $display("FAIL miss_c4: got done/hit/stb=%b want 100",
            {bif.lk_done, bif.lk_hit, bif.sc_stb});
      end
      cmp_cnt++;
      if (bif.lk_sprite !== 64'hA5) begin
         fail_cnt++; $display("FAIL miss_sprite_held: got %h want a5", bif.lk_sprite);
      end
      bif.lk_req = 1'b0;
      @(negedge clk); // cycle 5
      cmp_cnt++;
      if (bif.lk_done !== 1'b0) begin
         fail_cnt++; $display("FAIL miss_c5_done: got %b want 0", bif.lk_done);
      end
      hit_en = 1'b1;
   endtask

`ifndef SCARB_WRBUF_EN
   task automatic test_write();
      int w0;
      w0 = wr_cnt;
      bif.cpu_stb = 1'b1; bif.cpu_idx = 5'd7; bif.cpu_data = 64'h1234;
      @(negedge clk); // cycle 1
      cmp_cnt++;
      if ({bif.sc_stb, bif.sc_wr, bif.cpu_ack} !== 3'b110) begin
         fail_cnt++; $display("FAIL wr_c1: got stb/wr/ack=%b want 110", {bif.sc_stb, bif.sc_wr, bif.cpu_ack});
      end
      cmp_cnt++;
      if ({bif.sc_wr_idx, bif.sc_wr_sprite} !== {5'd7, 64'h1234}) begin
         fail_cnt++; $display("FAIL wr_payload: got idx %0d data %h want 7 / 1234",
            bif.sc_wr_idx, bif.sc_wr_sprite);
      end
      @(negedge clk); // cycle 2
      cmp_cnt++;
      if ({bif.sc_stb, bif.cpu_ack} !== 2'b01) begin
         fail_cnt++; $display("FAIL wr_c2: got stb/ack=%b want 01", {bif.sc_stb, bif.cpu_ack});
      end
      bif.cpu_stb = 1'b0;
      @(negedge clk); // cycle 3
      cmp_cnt++;
      if ({bif.sc_stb, bif.cpu_ack} !== 2'b00) begin
         fail_cnt++; $display("FAIL wr_c3: got stb/ack=%b want 00", {bif.sc_stb, bif.cpu_ack});
      end
      cmp_cnt++;
      if (wr_cnt - w0 !== 1) begin
         fail_cnt++; $display("FAIL wr_cycles: got %0d write cycles want 1", wr_cnt - w0);
      end
   endtask

   task automatic test_starvation();
      int w0, dones, acks, dones_at_ack, both;
      w0 = wr_cnt; dones = 0; acks = 0; dones_at_ack = -1; both = 0;
      found = 64'h55;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd50;
      bif.cpu_stb = 1'b1; bif.cpu_idx = 5'd9; bif.cpu_data = 64'hBEEF;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bif.lk_done && bif.cpu_ack) both++;
         if (bif.lk_done) begin
            dones++;
            if (dones == 9) bif.lk_req = 1'b0;
         end
         if (bif.cpu_ack) begin
            acks++;
            dones_at_ack = dones;
            bif.cpu_stb = 1'b0;
         end
      end
      cmp_cnt++;
      if (dones_at_ack !== 8) begin
         fail_cnt++; $display("FAIL starve_lookups_before_write: got %0d want 8", dones_at_ack);
      end
      cmp_cnt++;
      if (dones !== 9) begin
         fail_cnt++; $display("FAIL starve_lookups_resume: got %0d total want 9", dones);
      end
      cmp_cnt++;
      if (acks !== 1 || wr_cnt - w0 !== 1) begin
         fail_cnt++; $display("FAIL starve_write_once: got acks %0d writes %0d want 1/1", acks, wr_cnt - w0);
      end
      cmp_cnt++;
      if (both !== 0) begin
         fail_cnt++; $display("FAIL starve_done_ack_overlap: got %0d want 0", both);
      end
      cmp_cnt++;
      if (bif.sc_stb !== 1'b0) begin
         fail_cnt++; $display("FAIL starve_idle_end: got stb %b want 0", bif.sc_stb);
      end
   endtask
`else
   task automatic test_wrbuf();
      found = 64'h99;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd400;
      @(negedge clk); // cycle 1, lookup in progress
      bif.cpu_stb = 1'b1; bif.cpu_idx = 5'd3; bif.cpu_data = 64'hCAFE;
      @(negedge clk); // cycle 2
      cmp_cnt++;
      if ({bif.cpu_ack, bif.sc_wr} !== 2'b10) begin
         fail_cnt++; $display("FAIL wrbuf_early_ack: got ack/wr=%b want 10", {bif.cpu_ack, bif.sc_wr});
      end
      bif.cpu_stb = 1'b0;
      @(negedge clk); // cycle 3
      cmp_cnt++;
      if ({bif.lk_done, bif.lk_hit, bif.cpu_ack} !== 3'b110) begin
         fail_cnt++; $display("FAIL wrbuf_lookup_done: got done/hit/ack=%b want 110",
            {bif.lk_done, bif.lk_hit, bif.cpu_ack});
      end
      bif.lk_req = 1'b0;
      @(negedge clk); // cycle 4, IDLE after RELEASE
      cmp_cnt++;
      if (bif.sc_stb !== 1'b0) begin
         fail_cnt++; $display("FAIL wrbuf_release: got stb %b want 0", bif.sc_stb);
      end
      @(negedge clk); // cycle 5
      cmp_cnt++;
      if ({bif.sc_stb, bif.sc_wr, bif.sc_wr_idx, bif.sc_wr_sprite} !== {2'b11, 5'd3, 64'hCAFE}) begin
         fail_cnt++; $display("FAIL wrbuf_write: got stb/wr %b%b idx %0d data %h want 11 3 cafe",
            bif.sc_stb, bif.sc_wr, bif.sc_wr_idx, bif.sc_wr_sprite);
      end
      @(negedge clk); // cycle 6
      cmp_cnt++;
      if ({bif.sc_stb, bif.cpu_ack} !== 2'b00) begin
         fail_cnt++; $display("FAIL wrbuf_no_second_ack: got stb/ack=%b want 00", {bif.sc_stb, bif.cpu_ack});
      end
   endtask
`endif

   task automatic test_reset_mid_lookup();
      int dones, stbs;
      dones = 0; stbs = 0;
      hit_en = 1'b0;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd300;
      @(negedge clk); // cycle 1, in LOOKUP
      cmp_cnt++;
      if (bif.sc_stb !== 1'b1) begin
         fail_cnt++; $display("FAIL rstmid_in_lookup: got stb %b want 1", bif.sc_stb);
      end
      #2 reset = 1'b0;
      #1;
      cmp_cnt++;
      if ({bif.sc_stb, bif.sc_wr, bif.lk_done, bif.lk_hit, bif.cpu_ack} !== 5'b0) begin
         fail_cnt++; $display("FAIL rstmid_flags: got %b want 00000",
            {bif.sc_stb, bif.sc_wr, bif.lk_done, bif.lk_hit, bif.cpu_ack});
      end
      cmp_cnt++;
      if ({bif.sc_hcursor, bif.lk_sprite} !== 74'h0) begin
         fail_cnt++; $display("FAIL rstmid_data: got hcursor %0d sprite %h want 0", bif.sc_hcursor, bif.lk_sprite);
      end
      bif.lk_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      hit_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bif.lk_done) dones++;
         if (bif.sc_stb) stbs++;
      end
      cmp_cnt++;
      if (dones !== 0 || stbs !== 0) begin
         fail_cnt++; $display("FAIL rstmid_dropped: got dones %0d stbs %0d want 0/0", dones, stbs);
      end
      found = 64'h77;
      bif.lk_req = 1'b1; bif.lk_hcursor = 10'd301;
      repeat (3) @(negedge clk); // cycle 3
      cmp_cnt++;
      if ({bif.lk_done, bif.lk_hit, bif.lk_sprite, bif.sc_hcursor} !== {2'b11, 64'h77, 10'd301}) begin
         fail_cnt++; $display("FAIL rstmid_rerequest: got done/hit %b%b sprite %h hcursor %0d want 11 77 301",
            bif.lk_done, bif.lk_hit, bif.lk_sprite, bif.sc_hcursor);
      end
      bif.lk_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lookup_hit();
      test_lookup_miss();
`ifndef SCARB_WRBUF_EN
      test_write();
      test_starvation();
`else
      test_wrbuf();
`endif
      test_reset_mid_lookup();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
